// File: rtl/riscv_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: reset stretch, cycle budget, end-of-run detection.
// Optional write checksum enabled with `define RUN_CTRL_SIGNATURE_EN.
module riscv_run_ctrl #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     CNT_W       = 32,
    parameter int unsigned     RST_CYCLES  = 3,
    parameter int unsigned     MAX_CYCLES  = 1000,
    parameter int unsigned     STALL_LIMIT = 4,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_0FFC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             core_rst,
    output logic             clk_en,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             halted,
    output logic             timeout,
    output logic [XLEN-1:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      signature
);

    localparam int unsigned HOLD_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [2:0] {StHold, StRun, StPass, StFail, StHalt, StTimeout} state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    fail_code_q, fail_code_d;
    logic [XLEN-1:0]    pc_q;
    logic               pc_valid_q;
    logic               tohost_wr;
    logic               pc_repeat;

    assign tohost_wr = mem_we && (mem_addr == TOHOST_ADDR);
    // pc_valid_q keeps the first RUN cycle from comparing against a stale pc
    assign pc_repeat = pc_valid_q && (pc == pc_q);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stall_d     = stall_q;
        cnt_d       = cnt_q;
        fail_code_d = fail_code_q;
        case (state_q)
            StHold: begin
                if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRun: begin
                cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                stall_d = pc_repeat ? stall_q + 1'b1 : '0;
                if (tohost_wr && mem_wdata == XLEN'(1)) begin
                    state_d = StPass;
                end else if (tohost_wr && mem_wdata != '0) begin
                    state_d     = StFail;
                    fail_code_d = {1'b0, mem_wdata[XLEN-1:1]};
                end else if (pc_repeat && (stall_q + 1'b1) == STALL_W'(STALL_LIMIT)) begin
                    state_d = StHalt;
                end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d = StTimeout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StHold;
            hold_q      <= '0;
            stall_q     <= '0;
            cnt_q       <= '0;
            fail_code_q <= '0;
            pc_q        <= '0;
            pc_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stall_q     <= stall_d;
            cnt_q       <= cnt_d;
            fail_code_q <= fail_code_d;
            if (state_q == StRun) begin
                pc_q       <= pc;
                pc_valid_q <= 1'b1;
            end
        end
    end

`ifdef RUN_CTRL_SIGNATURE_EN
    logic [31:0] sig_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= '0;
        end else if (state_q == StRun && mem_we) begin
            sig_q <= {sig_q[30:0], sig_q[31]} ^ mem_wdata[31:0] ^ mem_addr[31:0];
        end
    end

    assign signature = sig_q;
`else
    assign signature = 32'h0;
`endif

    assign core_rst    = (state_q != StHold);
    assign running     = (state_q == StRun);
    assign clk_en      = running;
    assign pass        = (state_q == StPass);
    assign fail        = (state_q == StFail);
    assign halted      = (state_q == StHalt);
    assign timeout     = (state_q == StTimeout);
    assign done        = pass | fail | halted | timeout;
    assign fail_code   = fail_code_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Self-checking bench for riscv_run_ctrl: expected run outcomes are queued as each scenario
// is driven and compared once the controller reaches a terminal state.
module tb_riscv_run_ctrl;

    localparam logic [31:0] TOHOST = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        core_rst, clk_en, running, done, pass, fail, halted, timeout;
    logic [31:0] fail_code, cycle_count, signature;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  flags;  // {pass, fail, halted, timeout}
        logic [31:0] code;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];

    riscv_run_ctrl #(
        .XLEN        (32),
        .CNT_W       (32),
        .RST_CYCLES  (3),
        .MAX_CYCLES  (20),
        .STALL_LIMIT (4),
        .TOHOST_ADDR (TOHOST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .core_rst    (core_rst),
        .clk_en      (clk_en),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .halted      (halted),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .cycle_count (cycle_count),
        .signature   (signature)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of core activity and return at the following negedge.
    task automatic step(input logic [31:0] p, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
        pc        = p;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    task automatic do_reset(input bit full);
        rst       = 1'b0;
        pc        = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        repeat (2) @(negedge clk);
        if (full) begin
            check("rst_core_rst", core_rst, 0);
            check("rst_clk_en", clk_en, 0);
            check("rst_done", done, 0);
            check("rst_flags", {pass, fail, halted, timeout}, 0);
            check("rst_fail_code", fail_code, 0);
            check("rst_cycle_count", cycle_count, 0);
            check("rst_signature", signature, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("hold_edge1", core_rst, 0);
        @(negedge clk);
        check("hold_edge2", core_rst, 0);
        @(negedge clk);
        check("hold_edge3", core_rst, 1);
        check("run_running", running, 1);
        check("run_cnt0", cycle_count, 0);
    endtask

    // Keep stepping until done (bounded), then score against the oldest queued outcome.
    task automatic run_until_done(input string tag, input logic [31:0] p0, input bit hold,
                                  input int budget);
        exp_t e;
        int   k = 0;
        while (!done && k < budget) begin
            step(hold ? p0 : p0 + 32'(4 * k), 1'b0, '0, '0);
            k++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({e.tag, "_flags"}, {pass, fail, halted, timeout}, e.flags);
        check({e.tag, "_fail_code"}, fail_code, e.code);
        check({e.tag, "_cycle_count"}, cycle_count, e.cyc);
        check({e.tag, "_clk_en"}, clk_en, 0);
        check({e.tag, "_running"}, running, 0);
        check({e.tag, "_core_rst"}, core_rst, 1);
        repeat (3) step(p0, 1'b1, TOHOST, 32'h1);
        check({e.tag, "_sticky_flags"}, {pass, fail, halted, timeout}, e.flags);
        check({e.tag, "_sticky_cnt"}, cycle_count, e.cyc);
    endtask

    initial begin
        logic [31:0] exp_sig;

        // Reset stretch, counting, PASS at run cycle 10; store of 1 elsewhere is not tohost.
        do_reset(1'b1);
        sb.push_back('{tag: "pass", flags: 4'b1000, code: 32'h0, cyc: 32'd11});
        for (int k = 0; k < 10; k++) begin
            if (k == 0 || k == 1 || k == 5) check("cnt_step", cycle_count, 32'(k));
            step(32'(4 * k), k == 3, 32'h0000_0FF8, 32'h1);
        end
        check("run_c10", running, 1);
        step(32'd40, 1'b1, TOHOST, 32'h1);
        run_until_done("pass", 32'd44, 1'b0, 2);

        // Tohost 0 ignored, then 7 -> FAIL with code 3.
        do_reset(1'b0);
        sb.push_back('{tag: "fail", flags: 4'b0100, code: 32'h3, cyc: 32'd5});
        for (int k = 0; k < 3; k++) step(32'(4 * k), 1'b0, '0, '0);
        step(32'd12, 1'b1, TOHOST, 32'h0);
        check("zero_ignored", running, 1);
        check("zero_cnt", cycle_count, 4);
        step(32'd16, 1'b1, TOHOST, 32'h7);
        run_until_done("fail", 32'd20, 1'b0, 2);

        // PC self-loop from the first run cycle: four repeats -> HALT.
        do_reset(1'b0);
        sb.push_back('{tag: "halt", flags: 4'b0010, code: 32'h0, cyc: 32'd5});
        run_until_done("halt", 32'h40, 1'b1, 12);

        // Tohost pass on the same cycle the stall would halt: pass wins.
        do_reset(1'b0);
        sb.push_back('{tag: "halt_vs_pass", flags: 4'b1000, code: 32'h0, cyc: 32'd5});
        for (int k = 0; k < 4; k++) step(32'h40, 1'b0, '0, '0);
        step(32'h40, 1'b1, TOHOST, 32'h1);
        run_until_done("halt_vs_pass", 32'h40, 1'b1, 2);

        // No events: TIMEOUT at the cycle budget, then async reset out of the terminal state.
        do_reset(1'b0);
        sb.push_back('{tag: "timeout", flags: 4'b0001, code: 32'h0, cyc: 32'd20});
        run_until_done("timeout", 32'h0, 1'b0, 25);
        #2 rst = 1'b0;
        #1;
        check("term_rst_done", done, 0);
        check("term_rst_timeout", timeout, 0);
        check("term_rst_cnt", cycle_count, 0);
        check("term_rst_core_rst", core_rst, 0);
        @(negedge clk);

        // Async reset mid-run.
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) step(32'(4 * k), 1'b0, '0, '0);
        check("mid_cnt", cycle_count, 5);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_core_rst", core_rst, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_clk_en", clk_en, 0);
        check("mid_rst_cnt", cycle_count, 0);
        @(negedge clk);

        // Write checksum over two stores.
        do_reset(1'b0);
        step(32'd0, 1'b1, 32'h100, 32'hA5);
        step(32'd4, 1'b1, 32'h104, 32'h5A);
        step(32'd8, 1'b0, '0, '0);
`ifdef RUN_CTRL_SIGNATURE_EN
        exp_sig = 32'h0000_0214;
`else
        exp_sig = 32'h0;
`endif
        check("signature", signature, exp_sig);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
